// File: rtl/pc_pkg.sv
// Shared fetch-side definitions: branch opcodes, PC FSM encoding and default widths.
package pc_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_PC_STEP    = 4;

  // Opcodes resolved by the branch-equal-zero unit that produce BO.
  localparam logic [5:0] OP_JMP  = 6'b010100;
  localparam logic [5:0] OP_BEQZ = 6'b010101;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_REDIRECT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_flush_counter.sv
// Loadable down-counter that times the post-redirect squash window and gates new branches.
module pc_flush_counter #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic flush,
  output logic idle,
  output logic last
);

  logic [2:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (load) begin
      cnt <= 3'(FLUSH_CYCLES);
    end else if (cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign flush = (cnt != 3'd0);
  assign idle  = (cnt == 3'd0);
  assign last  = (cnt == 3'd1);

endmodule

// File: rtl/pc_branch_redirect.sv
// Program counter owner: sequential fetch with ready handshake, redirect on taken branch, flush window.
module pc_branch_redirect
  import pc_pkg::*;
#(
  parameter int                       ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]    RESET_ADDR   = '0,
  parameter int                       PC_STEP      = DEFAULT_PC_STEP,
  parameter int                       ALIGN_BITS   = 2,
  parameter int                       FLUSH_CYCLES = 2,
  parameter int                       CNT_WIDTH    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BO,
  input  logic                  BVALID,
  input  logic [ADDR_WIDTH-1:0] BTARGET,
  input  logic                  STALL,
  input  logic                  IMEM_READY,
  output logic [ADDR_WIDTH-1:0] IADDR,
  output logic                  IREQ,
  output logic                  FLUSH,
  output logic                  MISALIGN,
  output logic [CNT_WIDTH-1:0]  BCOUNT,
  output pc_state_t             DBG_STATE
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~({ADDR_WIDTH{1'b1}} << ALIGN_BITS);

  pc_state_t state, state_next;
  logic      flush_idle;
  logic      flush_last;
  logic      taken;
  logic      accept;

  // Wrong-path branches arriving while the flush counter runs are dropped by the idle gate.
  assign taken = BVALID & BO & flush_idle & (state != ST_BOOT);

  pc_flush_counter #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush (
    .clk  (CLK),
    .rst  (RST),
    .load (taken),
    .flush(FLUSH),
    .idle (flush_idle),
    .last (flush_last)
  );

  // Fetch handshake: IREQ is the valid, IMEM_READY the ready; a fetch is accepted
  // in any cycle both are high, IREQ never depends on IMEM_READY.
  always_comb begin
    state_next = state;
    IREQ       = 1'b0;
    case (state)
      ST_BOOT: state_next = ST_FETCH;
      ST_FETCH: IREQ = ~STALL;
      ST_REDIRECT: begin
        IREQ = ~STALL;
        if (flush_last) state_next = ST_FETCH;
      end
      default: state_next = ST_BOOT;
    endcase
    if (taken) state_next = ST_REDIRECT;
  end

  assign accept    = IREQ & IMEM_READY;
  assign DBG_STATE = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_BOOT;
      IADDR    <= RESET_ADDR;
      MISALIGN <= 1'b0;
      BCOUNT   <= '0;
    end else begin
      state <= state_next;
      // A redirect overrides an accept in the same cycle; that fetch is squashed by FLUSH.
      if (taken) begin
        IADDR <= BTARGET & ~ALIGN_MASK;
      end else if (accept) begin
        IADDR <= IADDR + ADDR_WIDTH'(PC_STEP);
      end
      if (taken && ((BTARGET & ALIGN_MASK) != '0)) begin
        MISALIGN <= 1'b1;
      end
      if (taken && (BCOUNT != {CNT_WIDTH{1'b1}})) begin
        BCOUNT <= BCOUNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_branch_redirect.sv
// Bench for pc_branch_redirect: vector table through a scoreboard queue, plus async-reset sequence.
module tb_pc_branch_redirect;
  import pc_pkg::*;

  localparam int W = 32 + 3 + 16;

  typedef struct {
    logic        rst;
    logic        bvalid;
    logic        bo;
    logic [31:0] btarget;
    logic        stall;
    logic        ready;
    logic [31:0] iaddr;
    logic        ireq;
    logic        flush;
    logic        mis;
    logic [15:0] bcount;
  } vec_t;

  logic        clk;
  logic        rst = 1'b1;
  logic        bo = 1'b0;
  logic        bvalid = 1'b0;
  logic [31:0] btarget = '0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] iaddr;
  logic        ireq;
  logic        flush;
  logic        misalign;
  logic [15:0] bcount;
  pc_state_t   dbg_state;

  logic [W-1:0] exp_q[$];
  vec_t         vecs[$];
  int           checks = 0;
  int           errors = 0;

  pc_branch_redirect dut (
    .CLK       (clk),
    .RST       (rst),
    .BO        (bo),
    .BVALID    (bvalid),
    .BTARGET   (btarget),
    .STALL     (stall),
    .IMEM_READY(imem_ready),
    .IADDR     (iaddr),
    .IREQ      (ireq),
    .FLUSH     (flush),
    .MISALIGN  (misalign),
    .BCOUNT    (bcount),
    .DBG_STATE (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(logic [31:0] a, logic r, logic f, logic m, logic [15:0] c);
    return {a, r, f, m, c};
  endfunction

  function automatic vec_t mk(logic r, logic bv, logic b, logic [31:0] t, logic s, logic rd,
                              logic [31:0] a, logic rq, logic f, logic m, logic [15:0] c);
    vec_t v;
    v.rst = r; v.bvalid = bv; v.bo = b; v.btarget = t; v.stall = s; v.ready = rd;
    v.iaddr = a; v.ireq = rq; v.flush = f; v.mis = m; v.bcount = c;
    return v;
  endfunction

  // scoreboard: pop the oldest expectation and compare with the live outputs
  task automatic check_outputs(input string name);
    logic [W-1:0] act;
    logic [W-1:0] exp;
    act = pack(iaddr, ireq, flush, misalign, bcount);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got iaddr=%h ireq=%b flush=%b mis=%b bcount=%0d, want iaddr=%h ireq=%b flush=%b mis=%b bcount=%0d",
               name, act[50:19], act[18], act[17], act[16], act[15:0],
               exp[50:19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 ns later
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    rst = v.rst; bvalid = v.bvalid; bo = v.bo; btarget = v.btarget;
    stall = v.stall; imem_ready = v.ready;
    exp_q.push_back(pack(v.iaddr, v.ireq, v.flush, v.mis, v.bcount));
    #1;
    check_outputs(name);
  endtask

  initial begin
    //                rst bv bo target        st rd  iaddr         rq fl mi cnt
    // reset, boot, sequential stepping
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 32'h0000_0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0000, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0004, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0008, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_000c, 1, 0, 0, 0));
    // three stall cycles hold the PC, then a not-ready cycle
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_0010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_0010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 1, 32'h0000_0010, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0010, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 32'h0000_0014, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0014, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0018, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_001c, 1, 0, 0, 0));
    // redirect under stall at 0x20, branches during the flush are ignored
    vecs.push_back(mk(0, 1, 1, 32'h100,      1, 1, 32'h0000_0020, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h300,      1, 1, 32'h0000_0100, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 32'h300,      0, 1, 32'h0000_0100, 1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0104, 1, 0, 0, 1));
    // misaligned redirect coinciding with an accept; later aligned redirect keeps MISALIGN
    vecs.push_back(mk(0, 1, 1, 32'h203,      0, 1, 32'h0000_0108, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0200, 1, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0204, 1, 1, 1, 2));
    vecs.push_back(mk(0, 1, 1, 32'h400,      0, 1, 32'h0000_0208, 1, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0400, 1, 1, 1, 3));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0404, 1, 1, 1, 3));
    // redirect to the top of the address space, then wrap on accept
    vecs.push_back(mk(0, 1, 1, 32'hffff_fffc, 0, 1, 32'h0000_0408, 1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'hffff_fffc, 1, 1, 1, 4));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0000, 1, 1, 1, 4));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 1, 32'h0000_0004, 1, 0, 1, 4));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // misaligned redirect, then asynchronous reset one cycle into the flush
    apply(mk(0, 1, 1, 32'h501, 0, 1, 32'h0000_0008, 1, 0, 1, 4), "redir_pre_reset");
    apply(mk(0, 0, 0, 32'h0,   0, 1, 32'h0000_0500, 1, 1, 1, 5), "redir_flush1");
    @(posedge clk);
    #3;
    exp_q.push_back(pack(32'h0000_0504, 1'b1, 1'b1, 1'b1, 16'd5));
    check_outputs("mid_flush");
    rst = 1'b1;
    #1;
    exp_q.push_back(pack(32'h0000_0000, 1'b0, 1'b0, 1'b0, 16'd0));
    check_outputs("async_reset");

    // after release the bench expects the same boot sequence as from power-up
    apply(mk(1, 0, 0, 32'h0, 0, 1, 32'h0000_0000, 0, 0, 0, 0), "rel_held");
    apply(mk(0, 0, 0, 32'h0, 0, 1, 32'h0000_0000, 0, 0, 0, 0), "rel_boot");
    for (int k = 0; k < 4; k++) begin
      apply(mk(0, 0, 0, 32'h0, 0, 1, 32'(k * 4), 1, 0, 0, 0), $sformatf("rel_step%0d", k));
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
